// File: rtl/tap_counter_pkg.sv
// Shared types and default tuning for the tap-gesture counter and the mode logic that consumes it.
package tap_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        EMIT     = 2'd2
    } tap_state_t;

    localparam int TAP_GAP_CYCLES_DEF = 2_000_000;
    localparam int TAP_MAX_TAPS_DEF   = 4;

endpackage

// File: rtl/tap_counter_gap_timer.sv
// Idle-gap timer: counts cycles since the last restart and flags the final cycle of the window.
module gap_timer #(
    parameter int GAP_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic expire
);

    localparam int TW = $clog2(GAP_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(GAP_CYCLES - 1);

    logic [TW-1:0] cnt_q;

    // Saturates at LAST so it can never wrap back into the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= '0;
        end else if (run && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + TW'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/tap_counter.sv
// Groups debounced press pulses into tap gestures and emits one registered result strobe per gesture.
module tap_counter
    import tap_pkg::*;
#(
    parameter int GAP_CYCLES = TAP_GAP_CYCLES_DEF,
    parameter int MAX_TAPS   = TAP_MAX_TAPS_DEF,
    parameter int CNT_W      = $clog2(MAX_TAPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             press_pulse,
    output logic             tap_valid,
    output logic [CNT_W-1:0] tap_count,
    output logic             busy
);

    tap_state_t       state_q;
    logic [CNT_W-1:0] count_q;
    logic             pending_q;
    logic             tap_valid_q;
    logic [CNT_W-1:0] tap_count_q;
    logic             busy_q;
    logic             run_s;
    logic             restart_s;
    logic             expire_s;

    assign run_s     = (state_q == COUNTING);
    assign restart_s = (state_q != COUNTING) || press_pulse;

    gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart_s),
        .run    (run_s),
        .expire (expire_s)
    );

    // Gesture FSM with registered strobe, count and busy outputs.
    // A press landing on the expiry edge closes the old gesture first and is replayed from EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pending_q   <= 1'b0;
            tap_valid_q <= 1'b0;
            tap_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            tap_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pending_q <= 1'b0;
                    if (press_pulse) begin
                        state_q <= COUNTING;
                        count_q <= CNT_W'(1);
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                COUNTING: begin
                    if (expire_s) begin
                        state_q     <= EMIT;
                        pending_q   <= press_pulse;
                        tap_valid_q <= 1'b1;
                        tap_count_q <= count_q;
                        busy_q      <= 1'b0;
                    end else if (press_pulse) begin
                        if (count_q == CNT_W'(MAX_TAPS - 1)) begin
                            state_q     <= EMIT;
                            count_q     <= CNT_W'(MAX_TAPS);
                            tap_valid_q <= 1'b1;
                            tap_count_q <= CNT_W'(MAX_TAPS);
                            busy_q      <= 1'b0;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end else begin
                        state_q <= COUNTING;
                    end
                end
                EMIT: begin
                    pending_q <= 1'b0;
                    if (press_pulse || pending_q) begin
                        state_q <= COUNTING;
                        count_q <= CNT_W'(1);
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    count_q   <= '0;
                    pending_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign tap_valid = tap_valid_q;
    assign tap_count = tap_count_q;
    assign busy      = busy_q;

endmodule
